kernel_launcher: RTL

- Upstream neighbour of the block dispatch unit.
- Accepts kernel launch requests (thread count) from the host/control side over a valid/ready handshake and buffers them in a small queue.
- Sequences each kernel through dispatch: reset, assert start, wait for done, retire.
- Reports per-kernel completion with a kernel ID and an elapsed-cycle count.

---
 rtl/gpu_pkg.sv | 20 ++
 rtl/kernel_launch_fifo.sv | 65 ++++++
 rtl/kernel_launcher.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the kernel launch path.
//   launch_entry_t   : one pending launch (assigned kernel ID + thread count)
//   launcher_state_t : kernel_launcher sequencing states
package gpu_pkg;

   localparam int KERNEL_ID_W = 8;

   typedef struct packed {
      logic [KERNEL_ID_W-1:0] kernel_id;
      logic [7:0]             thread_count;
   } launch_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      RUN    = 2'd2,
      RETIRE = 2'd3
   } launcher_state_t;

endpackage

// File: rtl/kernel_launch_fifo.sv
// Synchronous FIFO of pending kernel launches.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, push_data_i    write one entry (ignored when full)
//   pop_i, pop_data_o      read/remove head entry (ignored when empty);
//                          pop_data_o always shows the current head
//   flush_i                drop every stored entry
//   level_o, full_o, empty_o  occupancy
module kernel_launch_fifo
   import gpu_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  launch_entry_t push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output launch_entry_t pop_data_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   launch_entry_t mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          do_push, do_pop;

   assign full_o     = (level_q == LW'(DEPTH));
   assign empty_o    = (level_q == '0);
   assign level_o    = level_q;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/kernel_launcher.sv
// Kernel launcher: queues launch requests and sequences each kernel through
// the block dispatch unit (reset, start, wait for done, retire), reporting a
// completion with kernel ID and RUN cycle count.
// Ports:
//   clk, reset (async, active-low)
//   launch_valid/launch_ready/launch_thread_count/launch_kernel_id : request side
//   dispatch_reset/dispatch_start/dispatch_thread_count/dispatch_done : dispatch side
//   done_valid/done_kernel_id/done_cycles : completion report
//   queue_level, busy : status
// Optional build macro KERNEL_LAUNCHER_ABORT_EN adds input abort and output
// done_aborted (kills the running kernel and flushes the queue).
//
// state  | meaning
// IDLE   | dispatch held in reset; pop next entry when queue non-empty
// CLEAR  | one cycle of dispatch reset with the new thread count stable
// RUN    | dispatch started; count cycles until dispatch_done
// RETIRE | one cycle; report completion, then back to IDLE
module kernel_launcher
   import gpu_pkg::*;
#(
   parameter int  QUEUE_DEPTH = 4,
   parameter int  CYCLE_CNT_W = 16,
   localparam int LVL_W       = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
`ifdef KERNEL_LAUNCHER_ABORT_EN
   input  logic                   abort,
   output logic                   done_aborted,
`endif
   input  logic                   launch_valid,
   output logic                   launch_ready,
   input  logic [7:0]             launch_thread_count,
   output logic [KERNEL_ID_W-1:0] launch_kernel_id,
   output logic                   dispatch_reset,
   output logic                   dispatch_start,
   output logic [7:0]             dispatch_thread_count,
   input  logic                   dispatch_done,
   output logic                   done_valid,
   output logic [KERNEL_ID_W-1:0] done_kernel_id,
   output logic [CYCLE_CNT_W-1:0] done_cycles,
   output logic [LVL_W-1:0]       queue_level,
   output logic                   busy
);

   launcher_state_t        state_q, state_d;
   logic [KERNEL_ID_W-1:0] next_id_q, active_id_q;
   logic [CYCLE_CNT_W-1:0] cnt_q;
   logic [7:0]             thread_count_q;
   logic                   dispatch_reset_q, dispatch_start_q;
   logic                   done_valid_q;
   logic [KERNEL_ID_W-1:0] done_kernel_id_q;
   logic [CYCLE_CNT_W-1:0] done_cycles_q;
   logic                   busy_q;

   logic                   abort_w;
   logic                   push, pop;
   launch_entry_t          push_entry, head;
   logic                   fifo_full, fifo_empty;

`ifdef KERNEL_LAUNCHER_ABORT_EN
   logic aborted_q, done_aborted_q;
   assign abort_w      = abort;
   assign done_aborted = done_aborted_q;
`else
   assign abort_w = 1'b0;
`endif

   assign launch_ready     = !fifo_full && !abort_w;
   assign push             = launch_valid && launch_ready;
   assign launch_kernel_id = next_id_q;
   assign push_entry       = '{kernel_id: next_id_q, thread_count: launch_thread_count};

   kernel_launch_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (abort_w),
      .pop_data_o  (head),
      .level_o     (queue_level),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !abort_w) begin
               pop     = 1'b1;
               state_d = (head.thread_count == 8'd0) ? RETIRE : CLEAR;
            end
         end
         CLEAR:   state_d = abort_w ? RETIRE : RUN;
         RUN:     if (abort_w || dispatch_done) state_d = RETIRE;
         RETIRE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         next_id_q      <= '0;
         active_id_q    <= '0;
         thread_count_q <= '0;
         cnt_q          <= '0;
      end else begin
         state_q <= state_d;
         if (push) next_id_q <= next_id_q + KERNEL_ID_W'(1);
         if (pop) begin
            active_id_q    <= head.kernel_id;
            thread_count_q <= head.thread_count;
            cnt_q          <= '0;
         end else if (state_q == RUN && cnt_q != '1) begin
            cnt_q <= cnt_q + CYCLE_CNT_W'(1);
         end
      end
   end

   // Dispatch-facing and completion outputs are registered decodes of the
   // current state, so they trail the state register by one cycle. This is
   // what places the first start three edges after an accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dispatch_reset_q <= 1'b1;
         dispatch_start_q <= 1'b0;
         done_valid_q     <= 1'b0;
         done_kernel_id_q <= '0;
         done_cycles_q    <= '0;
         busy_q           <= 1'b0;
      end else begin
         dispatch_reset_q <= (state_q != RUN);
         dispatch_start_q <= (state_q == RUN);
         done_valid_q     <= (state_q == RETIRE);
         busy_q           <= (state_q != IDLE) || !fifo_empty;
         if (state_q == RETIRE) begin
            done_kernel_id_q <= active_id_q;
            done_cycles_q    <= cnt_q;
         end
      end
   end

`ifdef KERNEL_LAUNCHER_ABORT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aborted_q      <= 1'b0;
         done_aborted_q <= 1'b0;
      end else begin
         if (pop)
            aborted_q <= 1'b0;
         else if (abort_w && (state_q == CLEAR || state_q == RUN))
            aborted_q <= 1'b1;
         done_aborted_q <= (state_q == RETIRE) && aborted_q;
      end
   end
`endif

   assign dispatch_reset        = dispatch_reset_q;
   assign dispatch_start        = dispatch_start_q;
   assign dispatch_thread_count = thread_count_q;
   assign done_valid            = done_valid_q;
   assign done_kernel_id        = done_kernel_id_q;
   assign done_cycles           = done_cycles_q;
   assign busy                  = busy_q;

endmodule
